// File: rtl/rv_tb_pkg.sv
// Shared definitions for the run monitor: FSM state encoding and run result causes.
package rv_tb_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_PASS    = 3'd1,
        CAUSE_FAIL    = 3'd2,
        CAUSE_HANG    = 3'd3,
        CAUSE_TIMEOUT = 3'd4
    } cause_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at its all-ones value.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/run_monitor.sv
// Run controller for the core: sequences core reset, counts RUN cycles and stores,
// and ends the run on a tohost store, a stalled PC or a cycle timeout.
module run_monitor
    import rv_tb_pkg::*;
#(
    parameter int             IAW          = 6,
    parameter int             DAW          = 6,
    parameter int             DW           = 64,
    parameter int             CW           = 32,
    parameter int             RST_CYCLES   = 5,
    parameter int             MAX_CYCLES   = 135,
    parameter int             STALL_CYCLES = 16,
    parameter logic [DAW-1:0] TOHOST_ADDR  = 6'h3F,
    parameter logic [DW-1:0]  PASS_VALUE   = 64'd1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           restart,
    input  logic [IAW-1:0] i_mem_addr,
    input  logic           d_mem_we,
    input  logic [DAW-1:0] d_mem_addr,
    input  logic [DW-1:0]  d_mem_data,
    output logic           core_rst_n,
    output logic           running,
    output logic           done,
    output logic           pass,
    output logic           timeout,
    output logic           hang,
    output logic [DW-1:0]  exit_code,
    output logic [CW-1:0]  cycle_count,
    output logic [CW-1:0]  store_count
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t         r_state;
    state_t         w_state_next;
    cause_t         w_cause;
    logic [RCW-1:0] r_hold_cnt;
    logic           r_core_rst_n;
    logic           r_running;
    logic           r_done;
    logic           r_pass;
    logic           r_timeout;
    logic           r_hang;
    logic [DW-1:0]  r_exit_code;
    logic [CW-1:0]  w_cycle_count;
    logic [CW-1:0]  w_store_count;
    logic           w_in_run;
    logic           w_tohost;
    logic           w_timeout_hit;
    logic           w_hang_hit;

    assign w_in_run      = (r_state == ST_RUN);
    assign w_tohost      = d_mem_we && (d_mem_addr == TOHOST_ADDR);
    assign w_timeout_hit = (w_cycle_count == CW'(MAX_CYCLES - 1));

    generate
        if (STALL_CYCLES > 0) begin : g_stall
            localparam int SW = $clog2(STALL_CYCLES + 1);
            logic [IAW-1:0] r_prev_addr;
            logic [SW-1:0]  r_stall_cnt;
            logic           w_same;

            assign w_same = (i_mem_addr == r_prev_addr);

            // r_stall_cnt = consecutive RUN cycles so far whose PC matched the cycle before
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prev_addr <= '0;
                    r_stall_cnt <= '0;
                end else begin
                    r_prev_addr <= i_mem_addr;
                    if (!w_in_run || restart || !w_same) begin
                        r_stall_cnt <= '0;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + SW'(1);
                    end
                end
            end

            assign w_hang_hit = w_in_run && w_same && (r_stall_cnt == SW'(STALL_CYCLES - 1));
        end else begin : g_no_stall
            assign w_hang_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cause      = CAUSE_NONE;
        if (restart) begin
            w_state_next = ST_HOLD;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tohost) begin
                        w_state_next = ST_END;
                        w_cause      = (d_mem_data == PASS_VALUE) ? CAUSE_PASS : CAUSE_FAIL;
                    end else if (w_hang_hit) begin
                        w_state_next = ST_END;
                        w_cause      = CAUSE_HANG;
                    end else if (w_timeout_hit) begin
                        w_state_next = ST_END;
                        w_cause      = CAUSE_TIMEOUT;
                    end
                end
                ST_END: begin
                    w_state_next = ST_END;
                end
                default: begin
                    w_state_next = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt   <= RCW'(RST_CYCLES - 1);
            r_core_rst_n <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_hang       <= 1'b0;
            r_exit_code  <= '0;
        end else begin
            r_core_rst_n <= (w_state_next == ST_RUN);
            r_running    <= (w_state_next == ST_RUN);
            // Reload whenever outside HOLD so every HOLD entry starts a full count
            if ((r_state == ST_HOLD) && !restart) begin
                if (r_hold_cnt != '0) begin
                    r_hold_cnt <= r_hold_cnt - RCW'(1);
                end
            end else begin
                r_hold_cnt <= RCW'(RST_CYCLES - 1);
            end
            if (restart) begin
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
                r_timeout   <= 1'b0;
                r_hang      <= 1'b0;
                r_exit_code <= '0;
            end else begin
                case (w_cause)
                    CAUSE_PASS: begin
                        r_done <= 1'b1;
                        r_pass <= 1'b1;
                    end
                    CAUSE_FAIL: begin
                        r_done      <= 1'b1;
                        r_exit_code <= d_mem_data;
                    end
                    CAUSE_HANG: begin
                        r_done <= 1'b1;
                        r_hang <= 1'b1;
                    end
                    CAUSE_TIMEOUT: begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(.W(CW)) u_cycle_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (restart),
        .i_en    (w_in_run),
        .o_count (w_cycle_count)
    );

    sat_counter #(.W(CW)) u_store_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (restart),
        .i_en    (w_in_run && d_mem_we),
        .o_count (w_store_count)
    );

    assign core_rst_n  = r_core_rst_n;
    assign running     = r_running;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign hang        = r_hang;
    assign exit_code   = r_exit_code;
    assign cycle_count = w_cycle_count;
    assign store_count = w_store_count;

endmodule
